cache_port_arbiter: RTL

- Two-requester, round-robin arbiter that shares the single `cache_controller` access port between port 0 (instruction fetch) and port 1 (data load/store).
- Latches the winning request and presents it to the cache for as long as it is outstanding.
- Waits for cache `ready`, then returns read data with a one-cycle `ack`.
- Also provides a per-port grant counter and a watchdog timeout, for the hit-rate and performance reports.

---
 rtl/cache_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port round-robin arbiter in front of the single cache access port
module cache_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_req,
    input  logic             p0_rw,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_ack,
    output logic [31:0]      p0_rdata,
    output logic             p0_err,
    input  logic             p1_req,
    input  logic             p1_rw,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_ack,
    output logic [31:0]      p1_rdata,
    output logic             p1_err,
    output logic             c_valid,
    output logic [31:0]      c_address,
    output logic [31:0]      c_data_in,
    output logic             c_rw,
    input  logic [31:0]      c_data_out,
    input  logic             c_ready,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int WD_W = 16;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             c_valid_q, c_valid_d;
    logic             c_rw_q, c_rw_d;
    logic [31:0]      c_address_q, c_address_d;
    logic [31:0]      c_data_in_q, c_data_in_d;
    logic             p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic             p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [31:0]      p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             win;

    // On a tie the port that did not win last time goes next
    assign win = (p0_req && p1_req) ? ~last_grant_q : p1_req;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        c_valid_d    = c_valid_q;
        c_rw_d       = c_rw_q;
        c_address_d  = c_address_q;
        c_data_in_d  = c_data_in_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_err_d     = p0_err_q;
        p1_err_d     = p1_err_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        wdog_d       = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d      = S_ISSUE;
                    last_grant_d = win;
                    grant_d      = win;
                    busy_d       = 1'b1;
                    c_valid_d    = 1'b1;
                    c_rw_d       = win ? p1_rw    : p0_rw;
                    c_address_d  = win ? p1_addr  : p0_addr;
                    c_data_in_d  = win ? p1_wdata : p0_wdata;
                    if (!win && cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
                    if (win && cnt1_q != {CNT_W{1'b1}})  cnt1_d = cnt1_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                // Ready is not looked at here: it may still be high from the last access
                state_d = S_WAIT;
                wdog_d  = WD_W'(1);
            end
            S_WAIT: begin
                if (c_ready) begin
                    state_d   = S_RESP;
                    c_valid_d = 1'b0;
                    if (!grant_q) begin
                        p0_ack_d = 1'b1;
                        p0_err_d = 1'b0;
                        if (!c_rw_q) p0_rdata_d = c_data_out;
                    end else begin
                        p1_ack_d = 1'b1;
                        p1_err_d = 1'b0;
                        if (!c_rw_q) p1_rdata_d = c_data_out;
                    end
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    state_d   = S_RESP;
                    c_valid_d = 1'b0;
                    if (!grant_q) begin
                        p0_ack_d = 1'b1;
                        p0_err_d = 1'b1;
                    end else begin
                        p1_ack_d = 1'b1;
                        p1_err_d = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            c_valid_q    <= 1'b0;
            c_rw_q       <= 1'b0;
            c_address_q  <= 32'd0;
            c_data_in_q  <= 32'd0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p0_rdata_q   <= 32'd0;
            p1_rdata_q   <= 32'd0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            c_valid_q    <= c_valid_d;
            c_rw_q       <= c_rw_d;
            c_address_q  <= c_address_d;
            c_data_in_q  <= c_data_in_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            wdog_q       <= wdog_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign c_valid   = c_valid_q;
    assign c_address = c_address_q;
    assign c_data_in = c_data_in_q;
    assign c_rw      = c_rw_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
endmodule
